// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch initiator.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [3:0]  BYTE_SEL_WORD  = 4'b1111;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of {pc, instr} pairs between fetch and decode.
// Flush wins over push; head outputs read zero while empty.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic              do_pop;
    logic              do_push;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on a full buffer frees the slot the same-cycle push lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign head_instr = empty ? '0 : instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch initiator: sequential word requests, miss/redirect handling, decode buffer.
// Optional FETCH_PERF_CNT_EN adds saturating transfer and miss-cycle counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pipe_stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] mem_address,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  mem_byte_select,
    input  logic        mem_ready,
    input  logic [31:0] mem_dataout
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);
    fetch_state_t state;
    logic [31:0]  addr;
    logic [31:0]  target;
    logic [31:0]  redirect_target;
    logic         buf_full;
    logic         buf_empty;
    logic         pop;
    logic         push;
    logic         xfer;

    assign redirect_target = redirect_pc & ~32'h3;
    assign pop             = !buf_empty && !pipe_stall;
    assign xfer            = mem_ren && mem_ready;
    // Words completing while draining, or alongside a redirect, belong to the old path.
    assign push            = xfer && !redirect && (state != DRAIN);

    always_comb begin
        mem_ren = 1'b0;
        case (state)
            FETCH:       mem_ren = !buf_full || pop;
            MISS, DRAIN: mem_ren = 1'b1;
            default:     mem_ren = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            addr   <= RESET_PC;
            target <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect) begin
                        addr <= redirect_target;
                    end
                end
                FETCH, MISS: begin
                    if (redirect) begin
                        // An unaccepted request must stay on the bus until the controller takes it.
                        if (mem_ren && !mem_ready) begin
                            state  <= DRAIN;
                            target <= redirect_target;
                        end else begin
                            state <= FETCH;
                            addr  <= redirect_target;
                        end
                    end else if (xfer) begin
                        state <= FETCH;
                        addr  <= addr + 32'd4;
                    end else if (mem_ren) begin
                        state <= MISS;
                    end else begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        state <= FETCH;
                        addr  <= redirect ? redirect_target : target;
                    end else if (redirect) begin
                        target <= redirect_target;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fetch_buf #(
        .DATA_W (32),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .pop        (pop),
        .push_pc    (addr),
        .push_instr (mem_dataout),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_pc    (pc_out),
        .head_instr (instr_out)
    );

    assign instr_valid     = !buf_empty;
    assign mem_address     = addr;
    assign mem_wen         = 1'b0;
    assign mem_byte_select = BYTE_SEL_WORD;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_miss_cnt  <= '0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            end
            if (mem_ren && !mem_ready) begin
                perf_miss_cnt <= sat_inc(perf_miss_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        pipe_stall  = 1'b0;
    logic        mem_ready   = 1'b1;
    logic [31:0] junk        = 32'h0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] mem_address;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  mem_byte_select;
    logic [31:0] mem_dataout;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] cur     = RPC;
    logic [31:0] tgt     = RPC;
    bit          pending = 1'b0;
    bit          held    = 1'b0;
    bit          started = 1'b0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_miss  = 32'h0;

    always #5 clk = ~clk;

    assign mem_dataout = mem_ready ? (mem_address ^ KEY) : junk;

    fetch_ctrl #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .pipe_stall      (pipe_stall),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .mem_address     (mem_address),
        .mem_ren         (mem_ren),
        .mem_wen         (mem_wen),
        .mem_byte_select (mem_byte_select),
        .mem_ready       (mem_ready),
        .mem_dataout     (mem_dataout)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_miss_cnt   (perf_miss_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bump(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        do begin
            next_cycle();
            n++;
        end while (mem_address !== a && n < 64);
        check_eq("wait_addr", mem_address, a);
    endtask

    // Scoreboard: compare every cycle, then advance the model as the clock edge will.
    always @(negedge clk) begin : scoreboard
        bit exp_ren;
        bit pop_x;
        bit xf;
        if (!reset) begin
            check_eq("rst_mem_ren", 32'(mem_ren), 32'h0);
            check_eq("rst_valid", 32'(instr_valid), 32'h0);
            check_eq("rst_instr_out", instr_out, 32'h0);
            check_eq("rst_pc_out", pc_out, 32'h0);
            check_eq("rst_mem_address", mem_address, RPC);
`ifdef FETCH_PERF_CNT_EN
            check_eq("rst_perf_fetch", perf_fetch_cnt, 32'h0);
            check_eq("rst_perf_miss", perf_miss_cnt, 32'h0);
`endif
            q.delete();
            cur = RPC; tgt = RPC; pending = 0; held = 0; started = 0;
            m_fetch = 0; m_miss = 0;
        end else begin
            exp_ren = started && (pending || held || q.size() < DEPTH ||
                                  (q.size() > 0 && !pipe_stall));
            pop_x   = (q.size() > 0) && !pipe_stall;
            check_eq("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
            check_eq("pc_out", pc_out, (q.size() > 0) ? q[0] : 32'h0);
            check_eq("instr_out", instr_out, (q.size() > 0) ? (q[0] ^ KEY) : 32'h0);
            check_eq("mem_ren", 32'(mem_ren), 32'(exp_ren));
            check_eq("mem_address", mem_address, cur);
            check_eq("mem_wen", 32'(mem_wen), 32'h0);
            check_eq("byte_select", 32'(mem_byte_select), 32'hF);
`ifdef FETCH_PERF_CNT_EN
            check_eq("perf_fetch", perf_fetch_cnt, m_fetch);
            check_eq("perf_miss", perf_miss_cnt, m_miss);
`endif
            xf = exp_ren && mem_ready;
            if (exp_ren && !mem_ready) m_miss = bump(m_miss);
            if (pop_x) void'(q.pop_front());
            if (redirect) begin
                q.delete();
                if (exp_ren && !mem_ready) begin
                    pending = 1; tgt = redirect_pc & ~32'h3;
                end else begin
                    pending = 0; cur = redirect_pc & ~32'h3;
                end
            end else if (xf) begin
                if (pending) begin
                    pending = 0; cur = tgt;
                end else begin
                    q.push_back(cur); cur = cur + 32'd4; m_fetch = bump(m_fetch);
                end
            end
            held    = exp_ren && !mem_ready;
            started = 1;
        end
    end

    initial begin
        // Reset release, back-to-back hits
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); check_eq("t1_valid_c1", 32'(instr_valid), 32'h0);
        next_cycle();
        @(negedge clk); check_eq("t1_valid_c2", 32'(instr_valid), 32'h0);
        check_eq("t1_ren_c2", 32'(mem_ren), 32'h1);
        next_cycle();
        @(negedge clk); check_eq("t1_valid_c3", 32'(instr_valid), 32'h1);
        check_eq("t1_pc0", pc_out, 32'h0);
        check_eq("t1_instr0", instr_out, KEY);
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            @(negedge clk); check_eq("t1_pc_seq", pc_out, 32'(4 * k));
        end

        // Five-cycle miss at 0x10
        wait_addr(32'h10);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t2_addr_hold", mem_address, 32'h10);
            check_eq("t2_ren_hold", 32'(mem_ren), 32'h1);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk); check_eq("t2_addr_ready", mem_address, 32'h10);
        next_cycle();
        @(negedge clk); check_eq("t2_valid", 32'(instr_valid), 32'h1);
        check_eq("t2_pc", pc_out, 32'h10);

        // Decode stall for six cycles
        next_cycle();
        pipe_stall = 1'b1;
        repeat (5) next_cycle();
        @(negedge clk); check_eq("t3_ren_full", 32'(mem_ren), 32'h0);
        check_eq("t3_valid_full", 32'(instr_valid), 32'h1);
        check_eq("t3_head", pc_out, 32'h14);
        next_cycle();
        pipe_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check_eq("t3_pc_resume", pc_out, 32'h14 + 32'(4 * k));
            next_cycle();
        end

        // Redirect to 0x203 during a miss at 0x40
        wait_addr(32'h40);
        mem_ready = 1'b0;
        @(negedge clk); check_eq("t4_addr_a", mem_address, 32'h40);
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h203;
        @(negedge clk); check_eq("t4_addr_b", mem_address, 32'h40);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk); check_eq("t4_addr_c", mem_address, 32'h40);
        check_eq("t4_ren_c", 32'(mem_ren), 32'h1);
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk); check_eq("t4_addr_d", mem_address, 32'h40);
        next_cycle();
        @(negedge clk); check_eq("t4_addr_new", mem_address, 32'h200);
        check_eq("t4_valid_e", 32'(instr_valid), 32'h0);
        next_cycle();
        @(negedge clk); check_eq("t4_pc_new", pc_out, 32'h200);

        // Reset mid-miss, then redirect coinciding with a hit at 0x8
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        #2 reset = 1'b0;
        #1;
        check_eq("t5_async_ren", 32'(mem_ren), 32'h0);
        check_eq("t5_async_valid", 32'(instr_valid), 32'h0);
        check_eq("t5_async_addr", mem_address, RPC);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b1;
        wait_addr(32'h8);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk); check_eq("t5_ren_hit", 32'(mem_ren), 32'h1);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk); check_eq("t5_valid_gap", 32'(instr_valid), 32'h0);
        check_eq("t5_addr_new", mem_address, 32'h100);
        next_cycle();
        @(negedge clk); check_eq("t5_pc_new", pc_out, 32'h100);
        check_eq("t5_valid_new", 32'(instr_valid), 32'h1);

`ifdef FETCH_PERF_CNT_EN
        // Ten hits and a three-cycle miss from a fresh reset
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        repeat (10) next_cycle();
        mem_ready = 1'b0;
        repeat (3) next_cycle();
        mem_ready = 1'b1;
        next_cycle();
        check_eq("t6_perf_fetch", perf_fetch_cnt, 32'd11);
        check_eq("t6_perf_miss", perf_miss_cnt, 32'd3);
`endif

        // Randomized traffic, including redirects near the top of the address space
        next_cycle();
        for (int i = 0; i < 3000; i++) begin
            mem_ready   = ($urandom_range(0, 9) < 7);
            pipe_stall  = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                      : $urandom;
            junk        = $urandom;
            next_cycle();
        end
        redirect = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch initiator for the RISC-V core: drives sequential word addresses into the instruction-memory controller, honours its `memReady` stall, and delivers instruction/PC pairs to decode through a two-entry buffer with a valid/stall handshake. Sits between the PC/branch logic of the core and `memory_ctrl_i`. It also owns branch/jump redirects, so a redirect arriving during a cache miss is handled without corrupting the memory transaction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word aligned)
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, ≥2)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `redirect`  in  1  branch/jump taken; load new PC, flush buffer
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored, forced 0
- `pipe_stall`  in  1  decode cannot accept this cycle
- `instr_valid`  out  1  `instr_out`/`pc_out` hold a valid entry
- `instr_out`  out  32  instruction at buffer head
- `pc_out`  out  32  address of `instr_out`
- `mem_address`  out  32  byte address to memory controller
- `mem_ren`  out  1  read request
- `mem_wen`  out  1  tied 0
- `mem_byte_select`  out  4  tied 4'b1111
- `mem_ready`  in  1  controller `memReady`; 0 = miss in progress
- `mem_dataout`  in  32  controller read data, valid when `mem_ren && mem_ready`

## Operation
- Transfer: accepted in any cycle with `mem_ren=1 && mem_ready=1`; `mem_dataout` captured at that edge with PC = `mem_address`; `mem_address` then advances by 4.
- While `mem_ready=0`: `mem_address` and `mem_ren` held stable, no capture.
- FSM states: IDLE, FETCH, MISS, DRAIN.
  - IDLE: entered on reset; `mem_ren=0`; → FETCH on first edge after reset deasserts.
  - FETCH: `mem_ren=1` iff buffer not full or head popped this cycle; `mem_ready=0` with `mem_ren=1` → MISS.
  - MISS: hold request; `mem_ready=1` → capture, → FETCH; `redirect` → DRAIN.
  - DRAIN: hold old address and `mem_ren=1` until `mem_ready=1`; discard data; → FETCH at new PC.
- Redirect: highest priority. At the edge it is sampled, buffer flushed, next PC = `{redirect_pc[31:2],2'b00}`. In FETCH with same-cycle transfer, captured word is discarded. Redirect during DRAIN overwrites the pending target.
- Pop: head removed when `instr_valid && !pipe_stall`. Simultaneous push and pop on full buffer allowed.
- PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: `mem_address=RESET_PC`, `mem_ren=0`, `instr_valid=0`, `instr_out=0`, `pc_out=0`, buffer empty, state IDLE.
- Hit latency: request in cycle N, `instr_valid` in N+1. Sustained throughput of 1 instruction/cycle on hits with `pipe_stall=0`.
- Miss: `instr_valid` one cycle after the cycle `mem_ready` returns high.
- Redirect in cycle N: `instr_valid=0` in N+1; first new instruction valid no earlier than N+2.
- Reset asserted mid-miss: immediate return to IDLE; no handshake completion.
- `instr_out`/`pc_out` read 0 when buffer empty.

## Configuration
- `FETCH_PERF_CNT_EN`: adds outputs `perf_fetch_cnt[31:0]`, counting accepted transfers not discarded, and `perf_miss_cnt[31:0]`, counting cycles with `mem_ren && !mem_ready`. Both reset to 0 and saturate at 32'hFFFF_FFFF. When the macro is undefined, neither the ports nor the counters exist.

## Structure
- Package `fetch_pkg`: FSM state enum `fetch_state_t`, `FETCH_RESET_PC` default, constant `BYTE_SEL_WORD = 4'b1111`.
- Sub-module `fetch_buf`: synchronous FIFO of {pc, instr}. Provides flush, push, pop, full, empty and head outputs. Flush takes priority over push.

## Test plan
- Reset release with `mem_ready=1` and memory returning addr^32'hA5A5_A5A5: `pc_out` sequence 0,4,8,… with one instruction per cycle, first `instr_valid` 2 cycles after reset release.
- `mem_ready` low for 5 cycles at address 0x10: `mem_address` stays 0x10 and `mem_ren` stays 1 for all 5 cycles. `pc_out=0x10` is valid in the cycle after `mem_ready` rises.
- `pipe_stall=1` for 6 cycles: buffer fills to 2 entries and `mem_ren` drops. On release, `pc_out` continues without a gap or duplicate.
- Redirect to 0x203 during a miss at 0x40: `mem_address` holds 0x40 until ready and that data is discarded. Next request is 0x200, and no instruction with `pc_out=0x40` appears.
- Redirect to 0x100 coinciding with a hit at 0x8: the word at 0x8 is dropped and `pc_out` next shows 0x100.
- With `FETCH_PERF_CNT_EN`, 10 hits plus a 3-cycle miss: `perf_fetch_cnt=11`, `perf_miss_cnt=3`.
